// File: rtl/car_alarm_pkg.sv
// Shared types and default timing for the car alarm controller.
// State encoding is visible on the debug port, so the values are fixed.
package car_alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED   = 3'd0,
    ST_ARMING     = 3'd1,
    ST_ARMED      = 3'd2,
    ST_ENTRY      = 3'd3,
    ST_ALARM      = 3'd4,
    ST_WAIT_CLOSE = 3'd5
  } state_t;

  localparam int DEF_N_DOORS     = 4;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_ARM_DELAY   = 4;
  localparam int DEF_ENTRY_DELAY = 6;
  localparam int DEF_ALARM_TIME  = 8;

  // Owner is considered away (system live) in every state past ARMING.
  function automatic logic is_armed_state(input state_t s);
    return (s == ST_ARMED) || (s == ST_ENTRY) || (s == ST_ALARM) || (s == ST_WAIT_CLOSE);
  endfunction

endpackage

// File: rtl/car_alarm_ctrl_delay_counter.sv
// Loadable down-counter used for the arming, entry and siren delays.
// Load wins over enable; decrementing stops at zero so the count never wraps.
module delay_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/car_alarm_ctrl.sv
// N-door vehicle alarm: auto-arm after a quiet delay, entry grace, bounded siren.
// Optional trigger-door log is built when CAR_ALARM_TRIGLOG_EN is defined.
module car_alarm_ctrl
  import car_alarm_pkg::*;
#(
  parameter int N_DOORS     = DEF_N_DOORS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int ARM_DELAY   = DEF_ARM_DELAY,
  parameter int ENTRY_DELAY = DEF_ENTRY_DELAY,
  parameter int ALARM_TIME  = DEF_ALARM_TIME
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_DOORS-1:0] door,
  input  logic               ignicao,
  output logic               alarme,
  output logic               armed,
  output logic [CNT_W-1:0]   count,
  output logic [2:0]         state_o,
  output logic [N_DOORS-1:0] trig_door
);

  localparam logic [CNT_W-1:0] ARM_V   = CNT_W'(ARM_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_V = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_V = CNT_W'(ALARM_TIME - 1);

  state_t           state_q, state_d;
  logic             door_any;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  assign door_any = |door;

  delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (!door_any) begin
          state_d      = ST_ARMING;
          cnt_load     = 1'b1;
          cnt_load_val = ARM_V;
        end
      end
      ST_ARMING: begin
        if (door_any) begin
          cnt_load     = 1'b1;
          cnt_load_val = ARM_V;
        end else if (cnt_zero) begin
          state_d = ST_ARMED;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_ARMED: begin
        if (door_any) begin
          state_d      = ST_ENTRY;
          cnt_load     = 1'b1;
          cnt_load_val = ENTRY_V;
        end
      end
      // Closing the door again does not abort the grace period.
      ST_ENTRY: begin
        if (cnt_zero) begin
          state_d      = ST_ALARM;
          cnt_load     = 1'b1;
          cnt_load_val = ALARM_V;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_ALARM: begin
        if (cnt_zero) begin
          state_d = door_any ? ST_WAIT_CLOSE : ST_ARMED;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_WAIT_CLOSE: begin
        if (!door_any) begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase
    // Ignition overrides everything and leaves the counter parked at zero.
    if (ignicao) begin
      state_d      = ST_DISARMED;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
      cnt_en       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  assign alarme  = (state_q == ST_ALARM);
  assign armed   = is_armed_state(state_q);
  assign count   = cnt_value;
  assign state_o = state_q;

`ifdef CAR_ALARM_TRIGLOG_EN
  logic [N_DOORS-1:0] trig_q, trig_d;

  always_comb begin
    trig_d = trig_q;
    if ((state_q == ST_ARMED) && (state_d == ST_ENTRY)) begin
      trig_d = door;
    end else if ((state_q == ST_ENTRY) || (state_q == ST_ALARM)) begin
      trig_d = trig_q | door;
    end
    if (state_d == ST_DISARMED) begin
      trig_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_q <= '0;
    end else begin
      trig_q <= trig_d;
    end
  end

  assign trig_door = trig_q;
`else
  assign trig_door = '0;
`endif

endmodule

// File: tb/tb_car_alarm_ctrl.sv
// Table-driven bench for car_alarm_ctrl with an expected-value queue,
// plus a hand-written check that reset drops the siren without a clock edge.
module tb_car_alarm_ctrl;

  localparam int S_DIS  = 0;
  localparam int S_ARMG = 1;
  localparam int S_ARMD = 2;
  localparam int S_ENT  = 3;
  localparam int S_ALM  = 4;
  localparam int S_WAIT = 5;

  typedef struct {
    int         st;
    int         cnt;
    logic       alm;
    logic       arm;
    logic [3:0] trig;
  } exp_t;

  typedef struct {
    logic [3:0] door;
    logic       ign;
    exp_t       e;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [3:0] door;
  logic       ignicao;
  logic       alarme;
  logic       armed;
  logic [3:0] count;
  logic [2:0] state_o;
  logic [3:0] trig_door;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  car_alarm_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .door      (door),
    .ignicao   (ignicao),
    .alarme    (alarme),
    .armed     (armed),
    .count     (count),
    .state_o   (state_o),
    .trig_door (trig_door)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, expv);
    end
  endtask

  // Adds n vectors holding the same inputs; count steps down by 'step' each cycle.
  function automatic void run(input logic [3:0] d, input logic i, input int st,
                              input int c0, input int n, input int step,
                              input logic [3:0] tr);
    for (int k = 0; k < n; k++) begin
      vec_t v;
      v.door   = d;
      v.ign    = i;
      v.e.st   = st;
      v.e.cnt  = c0 - k * step;
      v.e.alm  = (st == S_ALM);
      v.e.arm  = (st == S_ARMD) || (st == S_ENT) || (st == S_ALM) || (st == S_WAIT);
`ifdef CAR_ALARM_TRIGLOG_EN
      v.e.trig = tr;
`else
      v.e.trig = 4'b0000;
`endif
      vecs.push_back(v);
    end
  endfunction

  initial begin
    exp_t e;
    n_chk  = 0;
    n_fail = 0;

    // Arm from reset
    run(4'h0, 1'b0, S_ARMG, 3, 4, 1, 4'h0);
    run(4'h0, 1'b0, S_ARMD, 0, 1, 0, 4'h0);
    // One-cycle door pulse: full entry, siren, back to armed
    run(4'h4, 1'b0, S_ENT,  5, 1, 1, 4'h4);
    run(4'h0, 1'b0, S_ENT,  4, 5, 1, 4'h4);
    run(4'h0, 1'b0, S_ALM,  7, 8, 1, 4'h4);
    run(4'h0, 1'b0, S_ARMD, 0, 1, 0, 4'h4);
    // Disarm during grace on the 3rd entry cycle
    run(4'h1, 1'b0, S_ENT,  5, 3, 1, 4'h1);
    run(4'h1, 1'b1, S_DIS,  0, 2, 0, 4'h0);
    // Arming restart on a door pulse at count 1
    run(4'h0, 1'b0, S_ARMG, 3, 3, 1, 4'h0);
    run(4'h8, 1'b0, S_ARMG, 3, 1, 0, 4'h0);
    run(4'h0, 1'b0, S_ARMG, 2, 3, 1, 4'h0);
    run(4'h0, 1'b0, S_ARMD, 0, 1, 0, 4'h0);
    // Door held through the siren
    run(4'h2, 1'b0, S_ENT,  5, 6, 1, 4'h2);
    run(4'h2, 1'b0, S_ALM,  7, 8, 1, 4'h2);
    run(4'h2, 1'b0, S_WAIT, 0, 2, 0, 4'h2);
    run(4'h0, 1'b0, S_ARMD, 0, 1, 0, 4'h2);
    // Ignition during siren
    run(4'h1, 1'b0, S_ENT,  5, 1, 1, 4'h1);
    run(4'h0, 1'b0, S_ENT,  4, 5, 1, 4'h1);
    run(4'h0, 1'b0, S_ALM,  7, 2, 1, 4'h1);
    run(4'h0, 1'b1, S_DIS,  0, 1, 0, 4'h0);
    // Ignition and door together from armed: ignition wins
    run(4'h0, 1'b0, S_ARMG, 3, 4, 1, 4'h0);
    run(4'h0, 1'b0, S_ARMD, 0, 1, 0, 4'h0);
    run(4'hF, 1'b1, S_DIS,  0, 1, 0, 4'h0);
    // Re-arm, trigger, OR a later door into the log, enter siren
    run(4'h0, 1'b0, S_ARMG, 3, 4, 1, 4'h0);
    run(4'h0, 1'b0, S_ARMD, 0, 1, 0, 4'h0);
    run(4'h4, 1'b0, S_ENT,  5, 1, 1, 4'h4);
    run(4'h8, 1'b0, S_ENT,  4, 1, 1, 4'hC);
    run(4'h0, 1'b0, S_ENT,  3, 4, 1, 4'hC);
    run(4'h0, 1'b0, S_ALM,  7, 2, 1, 4'hC);

    door    = 4'h0;
    ignicao = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state",  -1, int'(state_o), S_DIS);
    chk("reset_count",  -1, int'(count), 0);
    chk("reset_alarme", -1, int'(alarme), 0);
    chk("reset_armed",  -1, int'(armed), 0);
    chk("reset_trig",   -1, int'(trig_door), 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      door    = vecs[i].door;
      ignicao = vecs[i].ign;
      exp_q.push_back(vecs[i].e);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      chk("state",  i, int'(state_o), e.st);
      chk("count",  i, int'(count), e.cnt);
      chk("alarme", i, int'(alarme), int'(e.alm));
      chk("armed",  i, int'(armed), int'(e.arm));
      chk("trig",   i, int'(trig_door), int'(e.trig));
    end

    // Siren is on here; reset mid-cycle must clear it before any edge.
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_alarme", -2, int'(alarme), 0);
    chk("async_reset_state",  -2, int'(state_o), S_DIS);
    chk("async_reset_armed",  -2, int'(armed), 0);
    chk("async_reset_count",  -2, int'(count), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
